// File: rtl/fsm_driver_if.sv
// Request handshake and ring-FSM bus between the initiator (fsm_driver)
// and its environment. The slave view is the driver itself: it accepts
// requests and drives the state/strobes to the next-state block. The
// master view is the environment: it issues requests and returns y.
interface fsm_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_target;
    logic [1:0] a;
    logic       i0;
    logic       i1;
    logic       i2;
    logic [1:0] y;
    logic       done;
    logic       done_err;

    modport slave (
        input  req_valid, req_target, y,
        output req_ready, a, i0, i1, i2, done, done_err
    );

    modport master (
        output req_valid, req_target, y,
        input  req_ready, a, i0, i1, i2, done, done_err
    );
endinterface

// File: rtl/fsm_driver.sv
// Initiator for the 3-state ring FSM (0->1->2->0). Holds the state register,
// strobes the matching advance line, captures the returned next state and
// walks the ring until it reaches a requested target, checking each step.
module fsm_driver #(
    parameter int GAP   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    fsm_driver_if.slave      bus,
    input  logic             err_clr,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] step_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0]       GAP_RELOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0] st;
    logic [1:0] a_q;
    logic [1:0] n_q;
    logic [3:0] gap_q;
    logic       derr_q;

    logic       accept;
    logic       bad_req;
    logic       mismatch;
    logic       err_set;
    logic [1:0] n_acc;
    logic [1:0] y_exp;

    // Ring successor; state 3 is off the ring and maps back to 0.
    function automatic logic [1:0] ring_succ(input logic [1:0] s);
        return (s == 2'd2 || s == 2'd3) ? 2'd0 : s + 2'd1;
    endfunction

    // Number of forward steps from s to t around the 3-state ring.
    function automatic logic [1:0] ring_dist(input logic [1:0] t, input logic [1:0] s);
        logic [2:0] d;
        d = {1'b0, t} + 3'd3 - {1'b0, s};
        return (d >= 3'd3) ? 2'(d - 3'd3) : d[1:0];
    endfunction

    assign bus.req_ready = reset && (st == S_IDLE);
    assign bus.a         = a_q;
    assign bus.i0        = (st == S_STEP) && (a_q == 2'd0);
    assign bus.i1        = (st == S_STEP) && (a_q == 2'd1);
    assign bus.i2        = (st == S_STEP) && (a_q == 2'd2);
    assign bus.done      = (st == S_DONE);
    assign bus.done_err  = (st == S_DONE) && derr_q;
    assign busy          = (st != S_IDLE);

    // Request decode, step check and error-set conditions.
    always_comb begin
        accept   = bus.req_valid && bus.req_ready;
        bad_req  = (bus.req_target == 2'd3) || (a_q == 2'd3);
        n_acc    = ring_dist(bus.req_target, a_q);
        y_exp    = ring_succ(a_q);
        mismatch = (st == S_STEP) && (bus.y != y_exp);
        err_set  = (accept && bad_req) || mismatch;
    end

    // Control FSM: accept, step/wait loop, one-cycle done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st     <= S_IDLE;
            a_q    <= 2'd0;
            n_q    <= 2'd0;
            gap_q  <= 4'd0;
            derr_q <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (accept) begin
                        derr_q <= bad_req;
                        if (bad_req) begin
                            st <= S_DONE;
                            // A corrupted register is pulled back onto the ring.
                            if (a_q == 2'd3) a_q <= 2'd0;
                        end else if (n_acc == 2'd0) begin
                            st <= S_DONE;
                        end else begin
                            st  <= S_STEP;
                            n_q <= n_acc;
                        end
                    end
                end
                S_STEP: begin
                    a_q <= bus.y;
                    n_q <= n_q - 2'd1;
                    if (mismatch) begin
                        derr_q <= 1'b1;
                        st     <= S_DONE;
                    end else if (n_q == 2'd1) begin
                        st <= S_DONE;
                    end else if (GAP > 0) begin
                        st    <= S_WAIT;
                        gap_q <= GAP_RELOAD;
                    end
                end
                S_WAIT: begin
                    if (gap_q == 4'd0) st <= S_STEP;
                    else               gap_q <= gap_q - 4'd1;
                end
                default: begin
                    st     <= S_IDLE;
                    derr_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag; a new error wins over a same-cycle clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       err <= 1'b0;
        else if (err_set) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

    // Saturating count of strobes issued (one per STEP cycle).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_count <= '0;
        end else if (st == S_STEP && step_count != CNT_MAX) begin
            step_count <= step_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fsm_driver.sv
// Bench for fsm_driver: two instances (GAP=0 and GAP=3), a ring next-state
// model with an override on instance 0, and a per-instance scoreboard of
// expected request outcomes checked when done fires.
module tb_fsm_driver;

    typedef struct {
        int derr;
        int a_fin;
        int lat;
        int nstb;
        int first;
        int last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fsm_driver_if bus0();
    fsm_driver_if bus1();

    logic       clr0, clr1;
    logic       busy0, busy1, err0, err1;
    logic [7:0] cnt0, cnt1;
    logic       fen0;
    logic [1:0] fval0;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   m_a[2];
    int   pend[2], cyc[2], nstb[2], first[2], last[2], maxstb[2], stray[2], ndone[2];

    function automatic logic [1:0] ring_next(input logic [1:0] s);
        case (s)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    assign bus0.y = fen0 ? fval0 : ring_next(bus0.a);
    assign bus1.y = ring_next(bus1.a);

    fsm_driver #(.GAP(0), .CNT_W(8)) dut0 (
        .clock(clk), .reset(rst_n), .bus(bus0),
        .err_clr(clr0), .busy(busy0), .err(err0), .step_count(cnt0)
    );

    fsm_driver #(.GAP(3), .CNT_W(8)) dut1 (
        .clock(clk), .reset(rst_n), .bus(bus1),
        .err_clr(clr1), .busy(busy1), .err(err1), .step_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic mon_step(input int d, input logic [1:0] a, input logic i0, input logic i1,
                            input logic i2, input logic done, input logic derr,
                            input logic vld, input logic rdy, input logic rstn);
        int   stb;
        int   idx;
        exp_t e;
        if (!rstn) begin
            pend[d] = 0;
        end else begin
            stb = int'(i0) + int'(i1) + int'(i2);
            idx = i0 ? 0 : (i1 ? 1 : (i2 ? 2 : 3));
            if (pend[d] != 0) begin
                cyc[d]++;
                if (stb > maxstb[d]) maxstb[d] = stb;
                if (stb > 0) begin
                    nstb[d] += stb;
                    if (first[d] == 3) first[d] = idx;
                    last[d] = cyc[d];
                end
                if (done) begin
                    pend[d] = 0;
                    ndone[d]++;
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        chk($sformatf("d%0d_sb_underflow", d), 1, 0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("d%0d_done_err", d), 32'(derr), e.derr);
                        chk($sformatf("d%0d_a_final", d), 32'(a), e.a_fin);
                        chk($sformatf("d%0d_latency", d), cyc[d], e.lat);
                        chk($sformatf("d%0d_strobes", d), nstb[d], e.nstb);
                        chk($sformatf("d%0d_first_strobe", d), first[d], e.first);
                        chk($sformatf("d%0d_last_strobe_cyc", d), last[d], e.last);
                        chk($sformatf("d%0d_onehot", d), 32'(maxstb[d] <= 1), 1);
                    end
                end
            end else if (stb > 0 || done) begin
                stray[d]++;
            end
            if (vld && rdy) begin
                pend[d]   = 1;
                cyc[d]    = 0;
                nstb[d]   = 0;
                first[d]  = 3;
                last[d]   = 0;
                maxstb[d] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, bus0.a, bus0.i0, bus0.i1, bus0.i2, bus0.done, bus0.done_err,
                 bus0.req_valid, bus0.req_ready, rst_n);
        mon_step(1, bus1.a, bus1.i0, bus1.i1, bus1.i2, bus1.done, bus1.done_err,
                 bus1.req_valid, bus1.req_ready, rst_n);
    end

    task automatic send(input int d, input int t, input logic clr);
        exp_t e;
        int   a0;
        int   n;
        int   gap;
        a0  = m_a[d];
        gap = (d == 0) ? 0 : 3;
        if (t == 3 || a0 == 3) begin
            e = '{derr: 1, a_fin: (a0 == 3) ? 0 : a0, lat: 1, nstb: 0, first: 3, last: 0};
        end else begin
            n = (t - a0 + 3) % 3;
            if (n == 0) begin
                e = '{derr: 0, a_fin: a0, lat: 1, nstb: 0, first: 3, last: 0};
            end else if (d == 0 && fen0) begin
                e = '{derr: 1, a_fin: int'(fval0), lat: 2, nstb: 1, first: a0, last: 1};
            end else begin
                e = '{derr: 0, a_fin: t, lat: 1 + n + (n - 1) * gap, nstb: n, first: a0,
                      last: n + (n - 1) * gap};
            end
        end
        m_a[d] = e.a_fin;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        for (int w = 0; w < 50 && !(d == 0 ? bus0.req_ready : bus1.req_ready); w++) begin
            @(posedge clk); #1;
        end
        if (!(d == 0 ? bus0.req_ready : bus1.req_ready)) chk("ready_timeout", 0, 1);
        if (d == 0) begin
            bus0.req_valid = 1'b1; bus0.req_target = 2'(t); clr0 = clr;
        end else begin
            bus1.req_valid = 1'b1; bus1.req_target = 2'(t); clr1 = clr;
        end
        @(posedge clk); #1;
        bus0.req_valid = 1'b0; clr0 = 1'b0;
        bus1.req_valid = 1'b0; clr1 = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int s;
        s = ndone[d];
        for (int k = 0; k < 100 && ndone[d] == s; k++) begin
            @(posedge clk); #1;
        end
        if (ndone[d] == s) chk($sformatf("d%0d_done_timeout", d), 0, 1);
    endtask

    task automatic pulse_clr0();
        clr0 = 1'b1;
        @(posedge clk); #1;
        clr0 = 1'b0;
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_target = 2'd0;
        bus1.req_valid = 1'b0; bus1.req_target = 2'd0;
        clr0 = 1'b0; clr1 = 1'b0; fen0 = 1'b0; fval0 = 2'd0;
        for (int i = 0; i < 2; i++) begin
            m_a[i] = 0; pend[i] = 0; cyc[i] = 0; nstb[i] = 0; first[i] = 3;
            last[i] = 0; maxstb[i] = 0; stray[i] = 0; ndone[i] = 0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", 32'(bus0.a), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(bus0.done), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_ready", 32'(bus0.req_ready), 0);
        chk("rst_strobes", 32'({bus0.i0, bus0.i1, bus0.i2}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(bus0.req_ready), 1);

        // Two steps 0->2, then zero-step and one-step requests.
        send(0, 2, 1'b0); wait_done(0);
        chk("cnt_after_t1", 32'(cnt0), 2);
        chk("done_err_low", 32'(bus0.done_err), 0);
        send(0, 2, 1'b0); wait_done(0);
        send(0, 0, 1'b0); wait_done(0);
        chk("cnt_after_t2", 32'(cnt0), 3);

        // GAP=3 instance, with a request attempt ignored while busy.
        send(1, 2, 1'b0);
        bus1.req_valid = 1'b1; bus1.req_target = 2'd3;
        repeat (2) begin @(posedge clk); #1; end
        bus1.req_valid = 1'b0;
        wait_done(1);
        chk("gap_err_clean", 32'(err1), 0);
        chk("gap_cnt", 32'(cnt1), 2);

        // Illegal target, clear, and clear colliding with a new error.
        send(0, 3, 1'b0); wait_done(0);
        chk("err_illegal", 32'(err0), 1);
        pulse_clr0();
        chk("err_cleared", 32'(err0), 0);
        send(0, 3, 1'b1); wait_done(0);
        chk("err_set_wins", 32'(err0), 1);
        pulse_clr0();

        // Mismatch returning 0, then one returning 3 and the recovery.
        fen0 = 1'b1; fval0 = 2'd0;
        send(0, 2, 1'b0); wait_done(0);
        fen0 = 1'b0;
        chk("err_mismatch", 32'(err0), 1);
        chk("cnt_mismatch", 32'(cnt0), 4);
        pulse_clr0();
        fen0 = 1'b1; fval0 = 2'd3;
        send(0, 1, 1'b0); wait_done(0);
        fen0 = 1'b0;
        send(0, 1, 1'b0); wait_done(0);
        chk("a_recovered", 32'(bus0.a), 0);
        chk("err_bad_a", 32'(err0), 1);
        pulse_clr0();

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            send(0, (m_a[0] + 1) % 3, 1'b0);
            wait_done(0);
        end
        chk("cnt_saturated", 32'(cnt0), 255);

        // Reset in the middle of a request.
        t = (m_a[1] + 2) % 3;
        send(1, t, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_a", 32'(bus1.a), 0);
        chk("abort_busy", 32'(busy1), 0);
        chk("abort_strobes", 32'({bus1.i0, bus1.i1, bus1.i2}), 0);
        chk("abort_done", 32'(bus1.done), 0);
        chk("abort_cnt0", 32'(cnt0), 0);
        q1.delete();
        m_a[0] = 0; m_a[1] = 0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("no_stray_events", 32'(stray[0] + stray[1]), 0);
        chk("sb_drained", 32'(q0.size() + q1.size()), 0);
        chk("abort_cnt1", 32'(cnt1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
